// File: rtl/alu_cc_unit_pkg.sv
// Shared definitions for the condition-code unit: Y86 condition codes,
// CC bit positions and the condition-request FSM states.
package alu_cc_unit_pkg;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    // CC vector layout is {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_HOLD
    } cond_state_t;

endpackage

// File: rtl/alu_cc_unit_cond_eval.sv
// Combinational Y86 condition evaluator; codes above C_G flag an error and
// force the condition false.
module cond_eval
    import alu_cc_unit_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd,
    output logic       err
);

    logic w_zf;
    logic w_lt;

    assign w_zf = cc[CC_ZF];
    assign w_lt = cc[CC_SF] ^ cc[CC_OF];

    always_comb begin
        cnd = 1'b0;
        err = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = w_lt | w_zf;
            C_L:      cnd = w_lt;
            C_E:      cnd = w_zf;
            C_NE:     cnd = ~w_zf;
            C_GE:     cnd = ~w_lt;
            C_G:      cnd = ~w_lt & ~w_zf;
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_cc_unit.sv
// Condition-code register fed by the ALU, plus a request/response FSM that
// evaluates a Y86 condition against a snapshot of the CC taken at acceptance.
module alu_cc_unit
    import alu_cc_unit_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    input  logic [W-1:0] alu_result,
    input  logic         alu_overflow,
    input  logic         set_cc,
    input  logic         cc_stall,
    input  logic         cc_bubble,
    input  logic         cond_valid,
    input  logic [3:0]   cond_ifun,
    output logic         cond_ready,
    output logic         cnd_valid,
    input  logic         cnd_ready,
    output logic         cnd,
    output logic         cnd_err,
    output logic [2:0]   cc_out
);

    logic [2:0]  r_cc;
    logic [2:0]  r_snapCc;
    logic [3:0]  r_ifun;
    cond_state_t r_state;
    logic        r_condReady;
    logic        r_cndValid;
    logic        r_cnd;
    logic        r_cndErr;

    logic        w_ccUpdate;
    logic [2:0]  w_newCc;
    logic        w_evalCnd;
    logic        w_evalErr;

    // Bubble and stall both squash the write; only the FSM is left untouched.
    assign w_ccUpdate = alu_valid & set_cc & ~cc_bubble & ~cc_stall;

    always_comb begin
        w_newCc        = '0;
        w_newCc[CC_ZF] = (alu_result == '0);
        w_newCc[CC_SF] = alu_result[W-1];
        w_newCc[CC_OF] = alu_overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_ccUpdate) begin
            r_cc <= w_newCc;
        end
    end

    cond_eval u_condEval (
        .ifun (r_ifun),
        .cc   (r_snapCc),
        .cnd  (w_evalCnd),
        .err  (w_evalErr)
    );

    // The snapshot reads r_cc before this edge's update lands, so a
    // same-cycle CC write never leaks into the request being accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_snapCc    <= '0;
            r_ifun      <= '0;
            r_condReady <= 1'b1;
            r_cndValid  <= 1'b0;
            r_cnd       <= 1'b0;
            r_cndErr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cond_valid) begin
                        r_ifun      <= cond_ifun;
                        r_snapCc    <= r_cc;
                        r_condReady <= 1'b0;
                        r_state     <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_cnd      <= w_evalCnd;
                    r_cndErr   <= w_evalErr;
                    r_cndValid <= 1'b1;
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnd_ready) begin
                        r_cndValid  <= 1'b0;
                        r_condReady <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_cndValid  <= 1'b0;
                    r_condReady <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cond_ready = r_condReady;
    assign cnd_valid  = r_cndValid;
    assign cnd        = r_cnd;
    assign cnd_err    = r_cndErr;
    assign cc_out     = r_cc;

endmodule
